// File: rtl/dbus_byte_master_pkg.sv
// Shared definitions for the byte-stream dBus initiator.
// Opcodes, reply status codes and the packet FSM state encoding.
package dbus_byte_master_pkg;

   localparam logic [7:0] OP_WRITE   = 8'h01;
   localparam logic [7:0] OP_READ    = 8'h02;

   localparam logic [7:0] ST_OK      = 8'h00;
   localparam logic [7:0] ST_ERR     = 8'h01;
   localparam logic [7:0] ST_TIMEOUT = 8'h02;
   localparam logic [7:0] ST_BADOP   = 8'hFF;

   localparam logic [1:0] SIZE_WORD  = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WDATA,
      S_CMD,
      S_RSP_WAIT,
      S_TX_STATUS,
      S_TX_DATA
   } state_t;

endpackage

// File: rtl/dbus_byte_master.sv
// Host byte-stream to dBus bridge: parses read/write packets,
// issues single-word dBus commands and streams back status/data.
module dbus_byte_master
   import dbus_byte_master_pkg::*;
#(
   parameter int RSP_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic [7:0]  rx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        dbus_cmd_valid,
   input  logic        dbus_cmd_ready,
   output logic        dbus_cmd_payload_wr,
   output logic [31:0] dbus_cmd_payload_address,
   output logic [31:0] dbus_cmd_payload_data,
   output logic [1:0]  dbus_cmd_payload_size,
   input  logic        dbus_rsp_ready,
   input  logic        dbus_rsp_error,
   input  logic [31:0] dbus_rsp_data
);

   localparam int TW = $clog2(RSP_TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(RSP_TIMEOUT);

   state_t        state_q;
   state_t        state_d;
   logic [1:0]    cnt_q;
   logic          rdy_q;
   logic          wr_q;
   logic          rd_q;
   logic [31:0]   addr_q;
   logic [31:0]   data_q;
   logic [31:0]   rdata_q;
   logic [7:0]    status_q;
   logic [TW-1:0] tcnt_q;

   logic rx_fire;
   logic tx_fire;
   logic cmd_fire;
   logic last;

   assign rx_fire  = rx_valid && rx_ready;
   assign tx_fire  = tx_valid && tx_ready;
   assign cmd_fire = dbus_cmd_valid && dbus_cmd_ready;
   assign last     = (cnt_q == 2'd3);

   assign dbus_cmd_payload_wr      = wr_q;
   assign dbus_cmd_payload_address = {addr_q[31:2], 2'b00};
   assign dbus_cmd_payload_data    = data_q;
   assign dbus_cmd_payload_size    = SIZE_WORD;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      rx_ready       = 1'b0;
      tx_valid       = 1'b0;
      tx_data        = 8'h00;
      dbus_cmd_valid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            rx_ready = rdy_q;
            if (rx_fire) begin
               if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                  state_d = S_ADDR;
               end else begin
                  state_d = S_TX_STATUS;
               end
            end
         end
         S_ADDR: begin
            rx_ready = rdy_q;
            if (rx_fire && last) begin
               state_d = wr_q ? S_WDATA : S_CMD;
            end
         end
         S_WDATA: begin
            rx_ready = rdy_q;
            if (rx_fire && last) begin
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            dbus_cmd_valid = 1'b1;
            if (cmd_fire) begin
               state_d = wr_q ? S_TX_STATUS : S_RSP_WAIT;
            end
         end
         S_RSP_WAIT: begin
            if (dbus_rsp_ready || tcnt_q == TMAX) begin
               state_d = S_TX_STATUS;
            end
         end
         S_TX_STATUS: begin
            tx_valid = 1'b1;
            tx_data  = status_q;
            if (tx_fire) begin
               state_d = rd_q ? S_TX_DATA : S_IDLE;
            end
         end
         S_TX_DATA: begin
            tx_valid = 1'b1;
            tx_data  = rdata_q[{cnt_q, 3'b000} +: 8];
            if (tx_fire && last) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdy_q    <= 1'b0;
         cnt_q    <= 2'd0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         addr_q   <= 32'h0;
         data_q   <= 32'h0;
         rdata_q  <= 32'h0;
         status_q <= 8'h00;
         tcnt_q   <= '0;
      end else begin
         rdy_q <= 1'b1;
         unique case (state_q)
            S_IDLE: begin
               if (rx_fire) begin
                  cnt_q    <= 2'd0;
                  wr_q     <= (rx_data == OP_WRITE);
                  rd_q     <= (rx_data == OP_READ);
                  status_q <= ST_BADOP;
               end
            end
            S_ADDR: begin
               if (rx_fire) begin
                  addr_q <= {rx_data, addr_q[31:8]};
                  cnt_q  <= cnt_q + 2'd1;
               end
            end
            S_WDATA: begin
               if (rx_fire) begin
                  data_q <= {rx_data, data_q[31:8]};
                  cnt_q  <= cnt_q + 2'd1;
               end
            end
            S_CMD: begin
               if (cmd_fire) begin
                  tcnt_q   <= '0;
                  status_q <= ST_OK;
                  rdata_q  <= 32'h0;
               end
            end
            // a response in the same cycle as expiry still wins
            S_RSP_WAIT: begin
               if (dbus_rsp_ready) begin
                  status_q <= dbus_rsp_error ? ST_ERR : ST_OK;
                  rdata_q  <= dbus_rsp_error ? 32'h0 : dbus_rsp_data;
               end else if (tcnt_q == TMAX) begin
                  status_q <= ST_TIMEOUT;
               end else begin
                  tcnt_q <= tcnt_q + TW'(1);
               end
            end
            S_TX_DATA: begin
               if (tx_fire) begin
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
